map_rom_arbiter: RTL and testbench
==================================

// Module: map_rom_arbiter
// PURPOSE
//  Shares the single-port wall-rectangle map ROM (5-bit address, 38-bit {x0,y0,x1,y1} word) among several movers.
//  Movers are pacman and the ghosts; each runs a collision sweep over the rectangle list.
//  Round-robin grant; a burst is held while the owner keeps req high, with optional forced preemption.
//  Returned ROM words are steered back with a one-hot valid tag that tracks the ROM read latency.
//  Sits between the mover datapaths and the map_rom instance.
// PARAMETERS
//  NUM_REQ    4   number of requesters (index 0 = pacman, 1..3 = ghosts)
//  ADDR_W     5   ROM address width
//  DATA_W     38  ROM word width
//  ROM_LAT    1   ROM read latency in cycles (address at edge t -> data valid after edge t+ROM_LAT)
//  MAX_BURST  32  maximum consecutive granted cycles when another req is pending; 0 disables preemption
// PORTS
//  clk        in   1               system clock
//  reset_n    in   1               asynchronous, active-low reset
//  req        in   NUM_REQ         per-requester access request, level-held for the whole burst
//  addr_in    in   NUM_REQ*ADDR_W  packed addresses; requester k uses bits [k*ADDR_W +: ADDR_W]
//  grant      out  NUM_REQ         one-hot (or zero) registered grant
//  rom_addr   out  ADDR_W          address to map_rom
//  rom_data   in   DATA_W          map_rom q output
//  rd_data    out  DATA_W          rom_data forwarded to requesters
//  rd_valid   out  NUM_REQ         one-hot; rd_valid[k]=1 means rd_data is a word requested by k
//  busy       out  1               |grant
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - grant=0, rd_valid=0, rd_data=0, busy=0, burst count=0
//   - RR pointer=0, so requester 0 has top priority first; tag pipeline cleared
//   - rom_addr=0 while grant=0
//  FSM with two states:
//   - S_IDLE: grant=0; at the next edge, grant the first asserted req at or after the RR pointer; else stay.
//   - S_OWN (owner k, grant[k]=1):
//     - req[k]=1 and no preemption: hold grant, burst count +1.
//     - req[k]=0: at the same edge, grant the next asserted req after k in RR order, with zero bubble;
//       if none, go to S_IDLE.
//     - Preemption: MAX_BURST!=0, burst count==MAX_BURST-1, and another req is pending.
//       At the next edge the grant moves to that requester, even though req[k] is still high.
//       Requester k sees grant[k]=0 and must not advance its sweep until grant[k] returns.
//     - On every grant change: RR pointer = new owner + 1 (mod NUM_REQ); burst count = 0.
//  Address and read path:
//   - rom_addr is combinational: addr_in slice of the owner while grant!=0, else 0.
//   - Every cycle with grant[k]=1 is one read of addr_in[k] (no separate strobe).
//   - Tag pipeline of ROM_LAT stages carries the one-hot grant.
//     rd_valid = tag output; rd_data = rom_data when rd_valid!=0, else hold the last value.
//   - A read issued on the last granted cycle still returns to its issuer after ROM_LAT cycles.
//     This holds even if the grant has moved on; tags are never reassigned.
//  Edge cases:
//   - Simultaneous req rise from several requesters: the lowest index at or after the RR pointer wins.
//   - req dropped and re-raised by the same requester while others wait: the others are served first.
//   - Owner drops req on the same edge preemption fires: treated as a normal release.
//   - Reset mid-burst: in-flight tags dropped and no rd_valid pulse follows.
//     Requesters restart their sweep from rectangle 0.
//   - Burst count saturates at MAX_BURST-1 when no other req is pending, so it never wraps.
// TESTING
//  1. Single req[0] held 21 cycles, addr 0..20:
//     grant[0] 1 cycle after req; rd_valid[0] for 21 cycles at 1+ROM_LAT lag; rd_data matches ROM words 0..20.
//  2. req=4'b0011 on the same edge after reset: grant[0] first; on drop of req[0] grant[1] at the same edge
//     with zero gap; the final read returns with rd_valid[0], not [1].
//  3. req=4'b1111 held, each requester drops after 21 cycles and re-raises:
//     grant order 0,1,2,3,0,1 and no requester starved.
//  4. MAX_BURST=8, req[2] held, then req[1] raised:
//     grant[2] drops after 8 cycles and grant[1] rises; grant returns to 2 after req[1] drops.
//  5. reset_n pulsed low mid-burst with a read in flight:
//     all outputs 0 immediately; no rd_valid afterwards; first grant after reset goes to requester 0.
//  6. req=0 for 100 cycles: grant=0, busy=0, rom_addr=0, rd_valid=0 throughout.

Source files
------------

// File: rtl/map_rom_arbiter_if.sv
// Mover-side request/address/grant/return bundle plus the map ROM port for map_rom_arbiter.
// The arbiter takes the slave view; the movers and the ROM model together form the master side.
interface map_rom_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = 38
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] addr_in;
   logic [NUM_REQ-1:0]        grant;
   logic [ADDR_W-1:0]         rom_addr;
   logic [DATA_W-1:0]         rom_data;
   logic [DATA_W-1:0]         rd_data;
   logic [NUM_REQ-1:0]        rd_valid;
   logic                      busy;

   modport slave (
      input  req, addr_in, rom_data,
      output grant, rom_addr, rd_data, rd_valid, busy
   );

   modport master (
      output req, addr_in, rom_data,
      input  grant, rom_addr, rd_data, rd_valid, busy
   );
endinterface

// File: rtl/map_rom_arbiter.sv
// Round-robin arbiter sharing the single-port wall-rectangle map ROM between pacman and the ghosts,
// with burst holding, optional forced preemption and a one-hot tag pipeline steering ROM words back.
module map_rom_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 38,
   parameter int ROM_LAT   = 1,
   parameter int MAX_BURST = 32
) (
   input logic              clk,
   input logic              reset_n,
   map_rom_arbiter_if.slave bus
);
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [BURST_W-1:0] BURST_LAST = (MAX_BURST > 1) ? BURST_W'(MAX_BURST - 1) : '0;
   localparam bit PREEMPT_EN = (MAX_BURST != 0);

   typedef enum logic {S_IDLE, S_OWN} state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_owner;
   logic [IDX_W-1:0]   r_ptr;
   logic [NUM_REQ-1:0] r_grant;
   logic [BURST_W-1:0] r_burst;
   logic [NUM_REQ-1:0] r_tag [ROM_LAT];
   logic [DATA_W-1:0]  r_rd_hold;

   logic               w_owner_req;
   logic               w_pick_hit;
   logic [IDX_W-1:0]   w_pick_idx;
   logic [IDX_W-1:0]   w_pick_next;
   logic [NUM_REQ-1:0] w_pick_onehot;
   logic               w_burst_last;
   logic               w_take;
   logic               w_to_idle;
   logic               w_burst_inc;
   logic [NUM_REQ-1:0] w_rd_valid;

   function automatic logic [IDX_W-1:0] rrIndex(input logic [IDX_W-1:0] base, input int offset);
      int sum;
      sum = int'(base) + offset;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IDX_W'(sum);
   endfunction

   // r_ptr always sits one past the owner, so a single scan serves idle pick, release and preemption.
   always_comb begin
      w_pick_hit = 1'b0;
      w_pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_pick_hit && bus.req[rrIndex(r_ptr, i)] &&
             !(r_state == S_OWN && rrIndex(r_ptr, i) == r_owner)) begin
            w_pick_hit = 1'b1;
            w_pick_idx = rrIndex(r_ptr, i);
         end
      end
   end

   assign w_owner_req   = bus.req[r_owner];
   assign w_pick_onehot = NUM_REQ'(1) << w_pick_idx;
   assign w_pick_next   = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
   assign w_burst_last  = PREEMPT_EN && (r_burst == BURST_LAST);

   assign w_take      = w_pick_hit && (r_state == S_IDLE || !w_owner_req || w_burst_last);
   assign w_to_idle   = (r_state == S_OWN) && !w_owner_req && !w_pick_hit;
   assign w_burst_inc = (r_state == S_OWN) && w_owner_req && PREEMPT_EN && !w_burst_last;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_owner <= '0;
         r_ptr   <= '0;
         r_grant <= '0;
         r_burst <= '0;
      end else if (w_take) begin
         r_state <= S_OWN;
         r_owner <= w_pick_idx;
         r_grant <= w_pick_onehot;
         r_ptr   <= w_pick_next;
         r_burst <= '0;
      end else if (w_to_idle) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_burst <= '0;
      end else if (w_burst_inc) begin
         r_burst <= r_burst + 1'b1;
      end
   end

   // Tags follow the issuing grant, so a read still returns to its issuer after the grant moves on.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ROM_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= r_grant;
         for (int i = 1; i < ROM_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   assign w_rd_valid = r_tag[ROM_LAT-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_hold <= '0;
      end else if (|w_rd_valid) begin
         r_rd_hold <= bus.rom_data;
      end
   end

   assign bus.grant    = r_grant;
   assign bus.busy     = |r_grant;
   assign bus.rd_valid = w_rd_valid;
   assign bus.rd_data  = (|w_rd_valid) ? bus.rom_data : r_rd_hold;
   assign bus.rom_addr = (|r_grant) ? bus.addr_in[r_owner*ADDR_W +: ADDR_W] : '0;
endmodule

// File: tb/tb_map_rom_arbiter.sv
// Bench for map_rom_arbiter: two instances (MAX_BURST 32 and 8) share one stimulus stream and
// are each compared against an integer-level arbitration model, plus directed corner sequences.
module tb_map_rom_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 38;
   localparam int ROM_LAT = 1;
   localparam int LIM_A   = 32;
   localparam int LIM_B   = 8;

   typedef struct {
      logic [NUM_REQ-1:0] req;
      logic [NUM_REQ-1:0] expGrant;
      logic [NUM_REQ-1:0] expValid;
   } vecT;

   logic                      clk = 1'b0;
   logic                      reset_n = 1'b0;
   logic [NUM_REQ-1:0]        reqDrv = '0;
   logic [NUM_REQ*ADDR_W-1:0] addrDrv = '0;
   logic [DATA_W-1:0]         romMem [32];
   logic [DATA_W-1:0]         romQA = '0;
   logic [DATA_W-1:0]         romQB = '0;

   int errCount = 0;
   int checkCount = 0;
   int pulseA0 = 0;
   bit randomAddr = 1'b0;

   int                 mOwn [2];
   int                 mPtr [2];
   int                 mCnt [2];
   int                 lim  [2];
   logic [NUM_REQ-1:0] eGrant [2];
   logic [NUM_REQ-1:0] eValid [2];
   logic [DATA_W-1:0]  eData  [2];
   int                 sweep  [NUM_REQ];
   vecT                vecs   [6];

   always #5 clk = ~clk;

   map_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifA ();
   map_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifB ();

   assign ifA.req      = reqDrv;
   assign ifA.addr_in  = addrDrv;
   assign ifA.rom_data = romQA;
   assign ifB.req      = reqDrv;
   assign ifB.addr_in  = addrDrv;
   assign ifB.rom_data = romQB;

   always @(posedge clk) begin
      romQA <= romMem[ifA.rom_addr];
      romQB <= romMem[ifB.rom_addr];
   end

   map_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .ROM_LAT(ROM_LAT), .MAX_BURST(LIM_A)) dutA (
      .clk(clk), .reset_n(reset_n), .bus(ifA));

   map_rom_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .ROM_LAT(ROM_LAT), .MAX_BURST(LIM_B)) dutB (
      .clk(clk), .reset_n(reset_n), .bus(ifB));

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pickFrom(input logic [NUM_REQ-1:0] r, input int start, input int skip);
      for (int i = 0; i < NUM_REQ; i++) begin
         int c = (start + i) % NUM_REQ;
         if (r[c] && c != skip) return c;
      end
      return -1;
   endfunction

   function automatic int ownerIdx(input logic [NUM_REQ-1:0] g);
      for (int k = 0; k < NUM_REQ; k++) if (g[k]) return k;
      return -1;
   endfunction

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         mOwn[d]   = -1;
         mPtr[d]   = 0;
         mCnt[d]   = 0;
         eGrant[d] = '0;
         eValid[d] = '0;
         eData[d]  = '0;
      end
      for (int k = 0; k < NUM_REQ; k++) sweep[k] = 0;
   endtask

   // One clock edge of the arbitration rules, using the inputs that were present before the edge.
   task automatic modelEdge(input int d, output int oldOwn);
      int newOwn;
      int other;
      oldOwn = mOwn[d];
      newOwn = oldOwn;
      if (oldOwn < 0) begin
         newOwn = pickFrom(reqDrv, mPtr[d], -1);
      end else if (!reqDrv[oldOwn]) begin
         newOwn = pickFrom(reqDrv, oldOwn + 1, -1);
      end else if (lim[d] != 0 && mCnt[d] == lim[d] - 1) begin
         other = pickFrom(reqDrv, oldOwn + 1, oldOwn);
         if (other >= 0) newOwn = other;
      end
      if (newOwn != oldOwn) begin
         mCnt[d] = 0;
         if (newOwn >= 0) mPtr[d] = (newOwn + 1) % NUM_REQ;
      end else if (newOwn >= 0 && lim[d] != 0 && mCnt[d] < lim[d] - 1) begin
         mCnt[d]++;
      end
      eValid[d] = (oldOwn >= 0) ? (NUM_REQ'(1) << oldOwn) : '0;
      if (oldOwn >= 0) eData[d] = romMem[addrDrv[oldOwn*ADDR_W +: ADDR_W]];
      eGrant[d] = (newOwn >= 0) ? (NUM_REQ'(1) << newOwn) : '0;
      mOwn[d] = newOwn;
   endtask

   task automatic checkComb(input int d);
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W-1:0] er;
      string n;
      n  = (d == 0) ? "A" : "B";
      er = (mOwn[d] >= 0) ? addrDrv[mOwn[d]*ADDR_W +: ADDR_W] : '0;
      ra = (d == 0) ? ifA.rom_addr : ifB.rom_addr;
      checkValue({n, " rom_addr"}, 64'(ra), 64'(er));
   endtask

   task automatic checkOutput(input int d);
      logic [NUM_REQ-1:0] g;
      logic [NUM_REQ-1:0] v;
      logic [DATA_W-1:0]  dat;
      logic               b;
      string              n;
      n = (d == 0) ? "A" : "B";
      if (d == 0) begin
         g = ifA.grant; v = ifA.rd_valid; dat = ifA.rd_data; b = ifA.busy;
      end else begin
         g = ifB.grant; v = ifB.rd_valid; dat = ifB.rd_data; b = ifB.busy;
      end
      checkValue({n, " grant"},    64'(g),   64'(eGrant[d]));
      checkValue({n, " rd_valid"}, 64'(v),   64'(eValid[d]));
      checkValue({n, " rd_data"},  64'(dat), 64'(eData[d]));
      checkValue({n, " busy"},     64'(b),   64'(|eGrant[d]));
      if (d == 0 && v[0] === 1'b1) pulseA0++;
   endtask

   // Entered and left one time unit after a rising edge.
   task automatic applyStimulus(input logic [NUM_REQ-1:0] r);
      int oldA;
      int oldB;
      reqDrv = r;
      for (int k = 0; k < NUM_REQ; k++)
         addrDrv[k*ADDR_W +: ADDR_W] = randomAddr ? ADDR_W'($urandom) : ADDR_W'(sweep[k]);
      #2;
      checkComb(0);
      checkComb(1);
      @(posedge clk);
      modelEdge(0, oldA);
      modelEdge(1, oldB);
      if (oldA >= 0) sweep[oldA] = (sweep[oldA] + 1) % 32;
      #1;
      checkOutput(0);
      checkOutput(1);
   endtask

   task automatic doReset();
      #2;
      reset_n = 1'b0;
      #1;
      modelReset();
      checkOutput(0);
      checkOutput(1);
      checkComb(0);
      checkComb(1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      int                 seen [$];
      int                 expOrder [6];
      int                 heldCnt [NUM_REQ];
      int                 run2;
      int                 activity;
      int                 len;
      logic [NUM_REQ-1:0] r;
      logic [NUM_REQ-1:0] prevG;

      vecs[0] = '{4'b0011, 4'b0001, 4'b0000};
      vecs[1] = '{4'b0011, 4'b0001, 4'b0001};
      vecs[2] = '{4'b0010, 4'b0010, 4'b0001};
      vecs[3] = '{4'b0010, 4'b0010, 4'b0010};
      vecs[4] = '{4'b0000, 4'b0000, 4'b0010};
      vecs[5] = '{4'b0000, 4'b0000, 4'b0000};
      expOrder = '{0, 1, 2, 3, 0, 1};
      lim[0] = LIM_A;
      lim[1] = LIM_B;
      for (int i = 0; i < 32; i++) romMem[i] = DATA_W'({$urandom(), $urandom()});

      modelReset();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      $display("[TB] reset state");
      checkOutput(0);
      checkOutput(1);
      checkComb(0);
      checkComb(1);

      $display("[TB] single requester sweep");
      doReset();
      pulseA0 = 0;
      repeat (21) applyStimulus(4'b0001);
      applyStimulus(4'b0000);
      checkValue("t1 rd_valid0 pulses", 64'(pulseA0), 64'd21);
      checkValue("t1 last word", 64'(ifA.rd_data), 64'(romMem[20]));
      applyStimulus(4'b0000);

      $display("[TB] zero-bubble handover table");
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].req);
         checkValue($sformatf("t2 grant row%0d", i), 64'(ifA.grant), 64'(vecs[i].expGrant));
         checkValue($sformatf("t2 valid row%0d", i), 64'(ifA.rd_valid), 64'(vecs[i].expValid));
      end

      $display("[TB] all requesters with drop and re-raise");
      doReset();
      for (int k = 0; k < NUM_REQ; k++) heldCnt[k] = 0;
      prevG = '0;
      for (int s = 0; s < 160 && seen.size() < 6; s++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (heldCnt[k] >= 21) begin
               r[k] = 1'b0;
               heldCnt[k] = 0;
            end else begin
               r[k] = 1'b1;
            end
         end
         applyStimulus(r);
         for (int k = 0; k < NUM_REQ; k++) if (eGrant[0][k]) heldCnt[k]++;
         if (ifA.grant != prevG && ifA.grant != '0) seen.push_back(ownerIdx(ifA.grant));
         prevG = ifA.grant;
      end
      checkValue("t3 grant changes seen", 64'(seen.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         if (i < seen.size()) checkValue($sformatf("t3 order%0d", i), 64'(seen[i]), 64'(expOrder[i]));
      applyStimulus(4'b0000);
      applyStimulus(4'b0000);

      $display("[TB] forced preemption");
      doReset();
      run2 = 0;
      for (int s = 0; s < 12; s++) begin
         applyStimulus((s < 3) ? 4'b0100 : 4'b0110);
         if (ifB.grant == 4'b0100) run2++;
      end
      checkValue("t4 B burst length", 64'(run2), 64'd8);
      checkValue("t4 B preempted grant", 64'(ifB.grant), 64'b0010);
      checkValue("t4 A kept grant", 64'(ifA.grant), 64'b0100);
      applyStimulus(4'b0100);
      checkValue("t4 B grant returns", 64'(ifB.grant), 64'b0100);
      applyStimulus(4'b0000);
      applyStimulus(4'b0000);

      $display("[TB] reset mid-burst");
      doReset();
      repeat (5) applyStimulus(4'b0100);
      doReset();
      repeat (3) applyStimulus(4'b0000);
      applyStimulus(4'b1111);
      checkValue("t5 A first grant", 64'(ifA.grant), 64'b0001);
      checkValue("t5 B first grant", 64'(ifB.grant), 64'b0001);
      applyStimulus(4'b0000);
      applyStimulus(4'b0000);

      $display("[TB] idle");
      activity = 0;
      repeat (100) begin
         applyStimulus(4'b0000);
         if (ifA.busy !== 1'b0 || ifA.rd_valid !== '0 || ifA.rom_addr !== '0) activity++;
      end
      checkValue("t6 idle activity", 64'(activity), 64'd0);

      $display("[TB] random traffic");
      randomAddr = 1'b1;
      doReset();
      for (int seg = 0; seg < 40; seg++) begin
         if (seg == 20) doReset();
         r = NUM_REQ'($urandom);
         len = $urandom_range(1, 30);
         for (int s = 0; s < len; s++) begin
            if ($urandom_range(0, 7) == 0) r[$urandom_range(0, NUM_REQ - 1)] ^= 1'b1;
            applyStimulus(r);
         end
      end
      applyStimulus(4'b0000);
      applyStimulus(4'b0000);

      $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end
endmodule
